// File: rtl/fp_seq_pkg.sv
// Shared types and constants for the floating-point sequencers.
package fp_seq_pkg;

    // Sequencer state; exposed on a debug port by each sequencer.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Bit positions inside the 5-bit exception flag vector.
    localparam int FLG_INVALID   = 4;
    localparam int FLG_INFINITE  = 3;
    localparam int FLG_OVERFLOW  = 2;
    localparam int FLG_UNDERFLOW = 1;
    localparam int FLG_INEXACT   = 0;
    localparam int NUM_FLAGS     = 5;

    // Positive zero is all-zero bits for any IEEE-style width; users slice it.
    localparam logic [63:0] FP_POS_ZERO = 64'h0;

endpackage

// File: rtl/fp_latency_watchdog.sv
// Counts cycles since an operation was issued and flags when the count
// would reach TIMEOUT. clear has priority over enable.
module fp_latency_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int               CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

    if (TIMEOUT < 4) begin : g_bad_timeout
        $error("fp_latency_watchdog: TIMEOUT must be at least 4");
    end

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise saturating increment while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires in the cycle whose increment would make the count reach TIMEOUT.
    assign expired = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/fp_reduce_seq.sv
// Streams len words from a comb-read memory through one pipelined FP adder,
// one operation in flight, and returns the sum with OR-ed exception flags.
// Calyx go/done handshake: go is a level sampled only in IDLE; done is a
// single-cycle pulse during which sum/flags/timeout_err are already valid.
module fp_reduce_seq
    import fp_seq_pkg::*;
#(
    parameter int expWidth   = 8,
    parameter int sigWidth   = 24,
    parameter int numWidth   = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic [2:0]            roundingMode,
    output logic [ADDR_WIDTH-1:0] mem_addr0,
    input  logic [numWidth-1:0]   mem_read_data,
    output logic                  add_val,
    output logic [numWidth-1:0]   add_a,
    output logic [numWidth-1:0]   add_b,
    output logic                  add_subOp,
    output logic [2:0]            add_roundingMode,
    input  logic [numWidth-1:0]   add_out,
    input  logic [4:0]            add_exceptionFlags,
    input  logic                  add_done,
    output logic [numWidth-1:0]   sum,
    output logic [4:0]            flags,
    output logic                  timeout_err,
    output logic                  done,
    output logic [2:0]            dbg_state
);

    localparam int                  IW       = ADDR_WIDTH + 1;
    localparam logic [IW-1:0]       MAX_LEN  = IW'(1 << ADDR_WIDTH);
    localparam logic [numWidth-1:0] POS_ZERO = FP_POS_ZERO[numWidth-1:0];

    if (numWidth != expWidth + sigWidth) begin : g_bad_width
        $error("fp_reduce_seq: numWidth must equal expWidth + sigWidth");
    end

    state_t                state_q, state_d;
    logic [IW-1:0]         len_q, len_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [IW-1:0]         idx_next;
    logic [IW-1:0]         len_clamped;
    logic [numWidth-1:0]   acc_q, acc_d;
    logic [numWidth-1:0]   b_q, b_d;
    logic [numWidth-1:0]   sum_q, sum_d;
    logic [4:0]            flags_q, flags_d;
    logic                  terr_q, terr_d;
    logic                  done_q, done_d;
    logic                  add_val_q, add_val_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wd_clear;
    logic                  wd_enable;
    logic                  wd_expired;

    // Lengths beyond the memory depth are treated as a full-memory reduction.
    assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;

    fp_latency_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // Next-state and datapath decode. Outputs (done, add_val, address) are
    // computed for the state being entered so they come straight from flops.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        b_d       = b_q;
        sum_d     = sum_q;
        flags_d   = flags_q;
        terr_d    = terr_q;
        done_d    = 1'b0;
        add_val_d = 1'b0;
        addr_d    = '0;
        wd_clear  = 1'b0;
        wd_enable = 1'b0;
        idx_next  = idx_q + IW'(1);

        case (state_q)
            IDLE: begin
                if (go) begin
                    len_d   = len_clamped;
                    acc_d   = POS_ZERO;
                    flags_d = '0;
                    terr_d  = 1'b0;
                    idx_d   = '0;
                    if (len_clamped == '0) begin
                        sum_d   = POS_ZERO;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        addr_d  = '0;
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                // Address is already on mem_addr0; capture the element.
                b_d       = mem_read_data;
                add_val_d = 1'b1;
                wd_clear  = 1'b1;
                state_d   = ISSUE;
            end
            ISSUE: begin
                wd_enable = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                if (add_done) begin
                    acc_d   = add_out;
                    flags_d = flags_q | add_exceptionFlags;
                    idx_d   = idx_next;
                    if (idx_next == len_q) begin
                        sum_d   = add_out;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        addr_d  = idx_next[ADDR_WIDTH-1:0];
                        state_d = FETCH;
                    end
                end else begin
                    wd_enable = 1'b1;
                    if (wd_expired) begin
                        // Abandon the run; acc keeps its last good value.
                        terr_d  = 1'b1;
                        sum_d   = acc_q;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All sequencer state; reset aborts any run without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            len_q     <= '0;
            idx_q     <= '0;
            acc_q     <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            flags_q   <= '0;
            terr_q    <= 1'b0;
            done_q    <= 1'b0;
            add_val_q <= 1'b0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            b_q       <= b_d;
            sum_q     <= sum_d;
            flags_q   <= flags_d;
            terr_q    <= terr_d;
            done_q    <= done_d;
            add_val_q <= add_val_d;
            addr_q    <= addr_d;
        end
    end

    // Operands come from registers that only change at FETCH (b) or on
    // add_done (acc), so they are stable for the whole operation.
    assign add_a            = acc_q;
    assign add_b            = b_q;
    assign add_subOp        = 1'b0;
    assign add_roundingMode = roundingMode;
    assign add_val          = add_val_q;
    assign mem_addr0        = addr_q;
    assign sum              = sum_q;
    assign flags            = flags_q;
    assign timeout_err      = terr_q;
    assign done             = done_q;
    assign dbg_state        = state_q;

endmodule
